// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types, defaults and helpers for the serial pattern detector
// Contents: controller state enum, default pattern size parameters,
// and the pattern-length clamp used when the run configuration is captured.
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_LEN_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    DONE,
    EXPIRED
  } state_t;

  // A length of 0 is read as 1; anything longer than the window is cut to it.
  function automatic int clamp_len(input int len, input int max_len);
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/pattern_window.sv
// rtl/pattern_window.sv - bit-stream shift window, fill counter and masked pattern compare
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   clear         empty the window and fill count (start of a run)
//   shift         accept x into the window this cycle
//   x             serial data bit
//   overlap       1 = keep history after a hit, 0 = require len fresh bits
//   len           clamped pattern length (1..MAX_LEN)
//   pattern       pattern, bit len-1 received first
//   hit           combinational: this shift completes a match
module pattern_window
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               shift,
  input  logic               x,
  input  logic               overlap,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] pattern,
  output logic               hit
);

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] window_next;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_next;

  always_comb begin
    window_next = {window[MAX_LEN-2:0], x};
    fill_next   = (fill < len) ? fill + LEN_W'(1) : len;
    mask        = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    // Newest bit sits at window[0], so the low len bits line up with pattern[len-1:0].
    hit = shift && (fill_next == len) && ((window_next & mask) == (pattern & mask));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      window <= '0;
      fill   <= '0;
    end else if (clear) begin
      window <= '0;
      fill   <= '0;
    end else if (shift) begin
      window <= window_next;
      fill   <= (hit && !overlap) ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - run controller for the serial pattern detector
// Ports:
//   clk, reset_n    clock and asynchronous active-low reset
//   start, abort    begin a run (captures cfg_*) / end the run at once
//   cfg_pattern     pattern, bit cfg_len-1 received first
//   cfg_len         pattern length, 0 -> 1, above MAX_LEN -> MAX_LEN
//   cfg_overlap     allow overlapping matches
//   cfg_target      matches needed to finish, 0 = unlimited
//   cfg_timeout     run limit in HUNT cycles, 0 = none
//   x_valid, x      qualified serial bit stream
//   match           one-cycle pulse per match
//   busy            run in progress
//   done            target reached (level)
//   timed_out       timeout expired (level)
//   match_count     matches in the current or last run, saturating
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int CNT_W   = 8,
  parameter int TO_W    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic [TO_W-1:0]    cfg_timeout,
  input  logic               x_valid,
  input  logic               x,
  output logic               match,
  output logic               busy,
  output logic               done,
  output logic               timed_out,
  output logic [CNT_W-1:0]   match_count
);

  state_t             state;
  logic [MAX_LEN-1:0] sh_pattern;
  logic [LEN_W-1:0]   sh_len;
  logic               sh_overlap;
  logic [CNT_W-1:0]   sh_target;
  logic [TO_W-1:0]    sh_timeout;
  logic [TO_W-1:0]    timer;

  logic               in_hunt;
  logic               accept;
  logic               shift;
  logic               hit;
  logic               expire;
  logic               target_hit;
  logic [CNT_W-1:0]   count_inc;

  assign in_hunt    = (state == HUNT);
  assign accept     = start && !abort && !in_hunt;
  assign shift      = in_hunt && x_valid && !abort;
  assign count_inc  = (match_count == '1) ? match_count : match_count + CNT_W'(1);
  assign target_hit = hit && (sh_target != '0) && (count_inc == sh_target);
  // Timer holds the number of HUNT cycles already completed, so the limit is T-1.
  assign expire     = (sh_timeout != '0) && (timer == sh_timeout - TO_W'(1));

  pattern_window #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept),
    .shift   (shift),
    .x       (x),
    .overlap (sh_overlap),
    .len     (sh_len),
    .pattern (sh_pattern),
    .hit     (hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      match       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      match_count <= '0;
      sh_pattern  <= '0;
      sh_len      <= '0;
      sh_overlap  <= 1'b0;
      sh_target   <= '0;
      sh_timeout  <= '0;
      timer       <= '0;
    end else begin
      match <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        done      <= 1'b0;
        timed_out <= 1'b0;
      end else begin
        case (state)
          HUNT: begin
            timer <= timer + TO_W'(1);
            if (hit) begin
              match       <= 1'b1;
              match_count <= count_inc;
            end
            // A completing match on the expiry cycle wins over the timeout.
            if (target_hit) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (expire) begin
              state     <= EXPIRED;
              busy      <= 1'b0;
              timed_out <= 1'b1;
            end
          end
          default: begin
            if (start) begin
              state       <= HUNT;
              busy        <= 1'b1;
              done        <= 1'b0;
              timed_out   <= 1'b0;
              match_count <= '0;
              timer       <= '0;
              sh_pattern  <= cfg_pattern;
              sh_len      <= LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
              sh_overlap  <= cfg_overlap;
              sh_target   <= cfg_target;
              sh_timeout  <= cfg_timeout;
            end
          end
        endcase
      end
    end
  end

endmodule
